// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter using the request-to-send sequence
// Ports: CLK/RST (sync, active high); tx_data/tx_start command request; tx_busy/tx_done/tx_ack status;
//        PS2_CLK_IN/PS2_DATA_IN raw line levels; PS2_CLK_DRV_LOW/PS2_DATA_DRV_LOW open-drain pull-downs.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES   = 12000,
  parameter int REQ_SETUP_CYCLES = 100,
  parameter int TIMEOUT_CYCLES   = 2000000,
  parameter int FILTER_LEN       = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_ack,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_DRV_LOW,
  output logic       PS2_DATA_DRV_LOW
);
  localparam int CW = $clog2((INHIBIT_CYCLES > REQ_SETUP_CYCLES ? INHIBIT_CYCLES : REQ_SETUP_CYCLES) + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW = $clog2(FILTER_LEN + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE} stateT;
  stateT         state;
  logic          clkS1, clkS2, dataS1, dataS2, clkFilt, fallEdge, ackBit, timedOut;
  logic [FW-1:0] filtCnt;
  logic [CW-1:0] cnt;
  logic [TW-1:0] toCnt;
  logic [9:0]    shiftReg;
  logic [3:0]    bitCnt;
  // the timeout window only covers the part of the transfer clocked by the device
  assign timedOut = (state inside {SEND, ACK, WAIT_IDLE}) && toCnt == TW'(TIMEOUT_CYCLES - 1);
  // line synchronizers and clock deglitch filter; idle lines read as high
  always_ff @(posedge CLK) begin
    if (RST) begin
      {clkS1, clkS2, dataS1, dataS2, clkFilt} <= '1;
      filtCnt <= '0;
      fallEdge <= 1'b0;
    end else begin
      {clkS1, clkS2, dataS1, dataS2} <= {PS2_CLK_IN, clkS1, PS2_DATA_IN, dataS1};
      fallEdge <= clkFilt && !clkS2 && filtCnt == FW'(FILTER_LEN - 1);
      if (clkS2 == clkFilt) filtCnt <= '0;
      else if (filtCnt == FW'(FILTER_LEN - 1)) begin
        clkFilt <= clkS2;
        filtCnt <= '0;
      end else filtCnt <= filtCnt + 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      toCnt <= '0;
      shiftReg <= '0;
      bitCnt <= '0;
      ackBit <= 1'b0;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      tx_ack <= 1'b0;
      PS2_CLK_DRV_LOW <= 1'b0;
      PS2_DATA_DRV_LOW <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      toCnt <= (state inside {SEND, ACK, WAIT_IDLE}) ? toCnt + 1'b1 : '0;
      if (timedOut) begin
        PS2_CLK_DRV_LOW <= 1'b0;
        PS2_DATA_DRV_LOW <= 1'b0;
        tx_done <= 1'b1;
        tx_ack <= 1'b0;
        state <= DONE;
      end else begin
        case (state)
          IDLE: if (tx_start) begin
            // frame shifted out LSB first: data, odd parity, stop
            shiftReg <= {1'b1, ~^tx_data, tx_data};
            tx_busy <= 1'b1;
            PS2_CLK_DRV_LOW <= 1'b1;
            cnt <= '0;
            state <= INHIBIT;
          end
          INHIBIT: if (cnt == CW'(INHIBIT_CYCLES)) begin
            PS2_DATA_DRV_LOW <= 1'b1;
            cnt <= '0;
            state <= REQ;
          end else cnt <= cnt + 1'b1;
          REQ: if (cnt == CW'(REQ_SETUP_CYCLES)) begin
            PS2_CLK_DRV_LOW <= 1'b0;
            bitCnt <= '0;
            state <= SEND;
          end else cnt <= cnt + 1'b1;
          SEND: if (fallEdge) begin
            PS2_DATA_DRV_LOW <= ~shiftReg[0];
            shiftReg <= {1'b1, shiftReg[9:1]};
            bitCnt <= bitCnt + 1'b1;
            if (bitCnt == 4'd9) state <= ACK;
          end
          ACK: if (fallEdge) begin
            ackBit <= ~dataS2;
            state <= WAIT_IDLE;
          end
          WAIT_IDLE: if (clkFilt && dataS2) begin
            tx_done <= 1'b1;
            tx_ack <= ackBit;
            state <= DONE;
          end
          DONE: begin
            tx_busy <= 1'b0;
            tx_ack <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter, the outbound counterpart of the keyboard receive path. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), using the PS/2 request-to-send sequence over open-drain PS2_CLK/PS2_DATA. It sits beside the keyboard receive controller under the top-level wrapper. It raises tx_busy so the receive path discards line activity while a transmission is in progress.

Parameters:
INHIBIT_CYCLES, 12000, CLK cycles the host holds PS2_CLK low before a request (120 us at 100 MHz)
REQ_SETUP_CYCLES, 100, CLK cycles PS2_DATA is held low before PS2_CLK is released
TIMEOUT_CYCLES, 2000000, cycles allowed from PS2_CLK release to end of transfer (20 ms)
FILTER_LEN, 8, consecutive equal synchronized samples required to accept a new PS2_CLK level

Ports:
CLK  in  1  system clock
RST  in  1  synchronous, active-high reset
tx_data  in  8  command byte, latched on an accepted tx_start
tx_start  in  1  one-cycle request; accepted only in IDLE
tx_busy  out  1  high from acceptance until the cycle after tx_done
tx_done  out  1  one-cycle pulse at the end of every accepted transfer
tx_ack  out  1  valid with tx_done: 1 = device acked, 0 = no ack or timeout
PS2_CLK_IN  in  1  raw PS2_CLK line level
PS2_DATA_IN  in  1  raw PS2_DATA line level
PS2_CLK_DRV_LOW  out  1  1 = pull PS2_CLK low; 0 = release (high-Z)
PS2_DATA_DRV_LOW  out  1  1 = pull PS2_DATA low; 0 = release

Behaviour:
- Reset: all outputs 0, both lines released, FSM in IDLE, counters cleared. RST mid-transfer releases both lines on the next edge and produces no tx_done.
- Inputs: 2-FF synchronizer on each line. The filtered clock changes level only after FILTER_LEN equal samples. Falling edge = filtered clock goes 1 to 0, registered as a one-cycle strobe. The data input is sampled in the synchronized domain.
- Parity: odd, par = ~^tx_data.
- IDLE: all drives 0. tx_start=1 latches tx_data, asserts tx_busy and goes to INHIBIT. tx_start is ignored while busy.
- INHIBIT: CLK_DRV_LOW=1 for INHIBIT_CYCLES cycles, then go to REQ.
- REQ: CLK_DRV_LOW=1 and DATA_DRV_LOW=1 (start bit) for REQ_SETUP_CYCLES. Then release the clock (CLK_DRV_LOW=0), clear bitcnt, start the timeout counter and go to SEND.
- SEND: on each falling edge, drive the next bit; DATA_DRV_LOW = ~bit.
  - Edges 1..8 carry tx_data[0..7], LSB first.
  - Edge 9 carries par.
  - Edge 10 carries the stop bit (release data), then go to ACK.
- ACK: data released. On the next (11th) falling edge, sample data: 0 gives ack=1, 1 gives ack=0. Then go to WAIT_IDLE.
- WAIT_IDLE: wait until filtered clock=1 and data=1, then go to DONE.
- DONE: tx_done=1 for one cycle with tx_ack=ack, then IDLE. tx_busy drops on that IDLE cycle.
- Timeout: if the timeout counter reaches TIMEOUT_CYCLES in SEND, ACK or WAIT_IDLE, release both lines and go to DONE with tx_ack=0.
- The timeout counter is not running in INHIBIT or REQ. No retry logic; the caller decides whether to resend.
- Edges seen outside SEND and ACK are ignored. Latency from accept to line release is INHIBIT_CYCLES + REQ_SETUP_CYCLES + 2 cycles.

Test Plan:
- Send 0xED with the device model clocking at 12.5 kHz and acking → data driven on edges 1..10 = 1,0,1,1,0,1,1,1, par=1, stop=1; tx_done with tx_ack=1; tx_busy high throughout.
- Send 0xF4 → bits 0,0,1,0,1,1,1,1 and par=0; send 0x00 → par=1; tx_ack=1 for both.
- Device never clocks after the request → after TIMEOUT_CYCLES, tx_done with tx_ack=0 and both drive outputs 0.
- Device holds data high on the 11th edge (no ack) → tx_done with tx_ack=0, no hang.
- tx_start pulsed during SEND with tx_data=0x55 → ignored; the original byte completes; a new start in IDLE afterwards is accepted.
- RST asserted at edge 5 → next cycle both drives 0, tx_busy=0, no tx_done. A 3-cycle glitch on PS2_CLK_IN (FILTER_LEN=8) produces no bit advance.
